// File: rtl/switch_box_cfg_loader_pkg.sv
// Shared types and helpers for the switch-box configuration loader.
package switch_box_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } cfg_state_t;

  // Single tracks take one config bit per side pair; double tracks pair up.
  function automatic int cfg_width(input int ws, input int wd);
    return (ws + wd / 2) * 6;
  endfunction

endpackage

// File: rtl/switch_box_cfg_loader_shift_reg.sv
// Shadow shift register for the config loader, with optional running parity.
// The parity output exists only when CFG_PARITY_EN is defined.
module cfg_shift_reg #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
`ifdef CFG_PARITY_EN
  ,
  output logic         par
`endif
);

  logic [W-1:0] shadow_d, shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (clr)
      shadow_d = '0;
    else if (shift_en)
      shadow_d = {shadow_q[W-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign q = shadow_q;

`ifdef CFG_PARITY_EN
  logic par_d, par_q;

  always_comb begin
    par_d = par_q;
    if (clr)
      par_d = 1'b0;
    else if (shift_en)
      par_d = par_q ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign par = par_q;
`endif

endmodule

// File: rtl/switch_box_cfg_loader.sv
// Serial config writer for one switch-box tile: shift CW bits, commit in one cycle.
// Define CFG_PARITY_EN to require a trailing even-parity bit per load.
module switch_box_cfg_loader
  import switch_box_cfg_pkg::*;
#(
  parameter  int WS = 8,
  parameter  int WD = 8,
  localparam int CW = cfg_width(WS, WD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  output logic          cfg_ready,
  output logic [CW-1:0] c,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int CNT_W = $clog2(CW + 1);

  cfg_state_t       state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [CW-1:0]    c_d, c_q;
  logic             done_d, done_q;
  logic             beat, shift_en, clr;
  logic [CW-1:0]    shadow;

`ifdef CFG_PARITY_EN
  logic err_d, err_q;
  logic par;
`endif

  cfg_shift_reg #(.W(CW)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (cfg_bit),
    .q        (shadow)
`ifdef CFG_PARITY_EN
    ,
    .par      (par)
`endif
  );

  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q == SHIFT) || (state_q == PARITY);
  assign beat      = cfg_valid & cfg_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    c_d      = c_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    clr      = 1'b0;
`ifdef CFG_PARITY_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = SHIFT;
          count_d = '0;
          clr     = 1'b1;
`ifdef CFG_PARITY_EN
          err_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (beat) begin
          shift_en = 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == CNT_W'(CW - 1)) begin
`ifdef CFG_PARITY_EN
            state_d = PARITY;
`else
            state_d = COMMIT;
`endif
          end
        end
      end
`ifdef CFG_PARITY_EN
      PARITY: begin
        // Even parity: trailing bit must equal the XOR of all data bits.
        if (beat) begin
          if (cfg_bit == par) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        c_d     = shadow;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

`ifdef CFG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign c    = c_q;
  assign done = done_q;

endmodule
